// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32I pipeline.
//   - Major opcode constants (inst[6:0]).
//   - Immediate-format select codes consumed by the sign-extension unit.
//   - Canonical NOP (addi x0, x0, 0).
package rv_pipe_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] IMM_SEL_I     = 3'b000;
  localparam logic [2:0] IMM_SEL_S     = 3'b001;
  localparam logic [2:0] IMM_SEL_B     = 3'b010;
  localparam logic [2:0] IMM_SEL_U     = 3'b011;
  localparam logic [2:0] IMM_SEL_J     = 3'b100;
  localparam logic [2:0] IMM_SEL_SHAMT = 3'b101;
  localparam logic [2:0] IMM_SEL_NONE  = 3'b111;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/imm_sel_decode.sv
// Immediate-format select decoder (purely combinational).
// Ports:
//   opcode  in  7  inst[6:0]
//   funct3  in  3  inst[14:12], only used to pick out shift-immediates
//   imm_sel out 3  format code for the sign-extension unit
module imm_sel_decode
  import rv_pipe_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [2:0] imm_sel
);

  always_comb begin
    imm_sel = IMM_SEL_NONE;
    case (opcode)
      OP_LOAD, OP_JALR:  imm_sel = IMM_SEL_I;
      // SLLI/SRLI/SRAI carry a 5-bit shamt plus funct7 in the I field.
      OP_IMM:            imm_sel = (funct3 == 3'b001 || funct3 == 3'b101) ?
                                   IMM_SEL_SHAMT : IMM_SEL_I;
      OP_STORE:          imm_sel = IMM_SEL_S;
      OP_BRANCH:         imm_sel = IMM_SEL_B;
      OP_LUI, OP_AUIPC:  imm_sel = IMM_SEL_U;
      OP_JAL:            imm_sel = IMM_SEL_J;
      default:           imm_sel = IMM_SEL_NONE;
    endcase
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a one-entry skid buffer.
// if_ready is a flop output, so fetch never sees a combinational path from
// id_ready. The immediate-select code is decoded before the register so it
// reaches decode straight from a flop.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop everything held (redirect from EX)
//   if_valid/if_ready     upstream handshake, if_pc/if_inst payload
//   id_valid/id_ready     downstream handshake
//   id_pc, id_inst        registered PC and instruction
//   id_imm_field          id_inst[31:7]
//   id_imm_sel            registered immediate format code
//   id_rs1/id_rs2/id_rd   register indices sliced from id_inst
module if_id_stage
  import rv_pipe_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_inst,
  output logic [24:0]     id_imm_field,
  output logic [2:0]      id_imm_sel,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd
);

  logic            valid_reg;
  logic            ready_reg;
  logic [XLEN-1:0] pc_reg;
  logic [31:0]     inst_reg;
  logic [2:0]      imm_sel_reg;

  logic            skid_valid_reg;
  logic [XLEN-1:0] skid_pc_reg;
  logic [31:0]     skid_inst_reg;

  logic            up_xfer;
  logic            main_load;
  logic [XLEN-1:0] src_pc;
  logic [31:0]     src_inst;
  logic [2:0]      src_imm_sel;

  assign up_xfer   = if_valid && ready_reg;
  // Main register may take a new entry when empty or its occupant leaves now.
  assign main_load = !valid_reg || id_ready;

  // The skid entry is older than anything on the fetch port, so it wins.
  assign src_pc   = skid_valid_reg ? skid_pc_reg   : if_pc;
  assign src_inst = skid_valid_reg ? skid_inst_reg : if_inst;

  imm_sel_decode u_imm_sel_decode (
    .opcode  (src_inst[6:0]),
    .funct3  (src_inst[14:12]),
    .imm_sel (src_imm_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg      <= 1'b0;
      ready_reg      <= 1'b1;
      pc_reg         <= RESET_PC;
      inst_reg       <= NOP_INST;
      imm_sel_reg    <= IMM_SEL_I;
      skid_valid_reg <= 1'b0;
      skid_pc_reg    <= '0;
      skid_inst_reg  <= NOP_INST;
    end else if (flush) begin
      // Any same-cycle fetch is discarded along with the held entries.
      valid_reg      <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b1;
    end else if (main_load) begin
      if (skid_valid_reg) begin
        // if_ready was low, so no upstream transfer can coincide here.
        valid_reg      <= 1'b1;
        pc_reg         <= src_pc;
        inst_reg       <= src_inst;
        imm_sel_reg    <= src_imm_sel;
        skid_valid_reg <= 1'b0;
        ready_reg      <= 1'b1;
      end else begin
        valid_reg <= up_xfer;
        if (up_xfer) begin
          pc_reg      <= src_pc;
          inst_reg    <= src_inst;
          imm_sel_reg <= src_imm_sel;
        end
        ready_reg <= 1'b1;
      end
    end else if (up_xfer) begin
      // Main is full and stalled: park the newcomer and close the door.
      skid_valid_reg <= 1'b1;
      skid_pc_reg    <= if_pc;
      skid_inst_reg  <= if_inst;
      ready_reg      <= 1'b0;
    end
  end

  assign if_ready     = ready_reg;
  assign id_valid     = valid_reg;
  assign id_pc        = pc_reg;
  assign id_inst      = inst_reg;
  assign id_imm_sel   = imm_sel_reg;
  assign id_imm_field = inst_reg[31:7];
  assign id_rs1       = inst_reg[19:15];
  assign id_rs2       = inst_reg[24:20];
  assign id_rd        = inst_reg[11:7];

endmodule
